// File: rtl/ddr_axi_2to1_arbiter.sv
// ddr_axi_2to1_arbiter: shares one DDR AXI-style port (combined A channel,
// W, R, B) between two requesters. Round-robin grant, one transaction in
// flight, watchdog on every post-grant state, sticky WLAST/length check.
module ddr_axi_2to1_arbiter #(
    parameter int unsigned DW         = 128,
    parameter int unsigned WDT_CYCLES = 4096
) (
    input  logic                  mem_clk,
    input  logic                  resetn,
    // requester A channels, lane i = bits [i*W +: W]
    input  logic [15:0]           s_aid,
    input  logic [63:0]           s_aaddr,
    input  logic [15:0]           s_alen,
    input  logic [5:0]            s_asize,
    input  logic [3:0]            s_aburst,
    input  logic [3:0]            s_alock,
    input  logic [1:0]            s_atype,
    input  logic [1:0]            s_avalid,
    output logic [1:0]            s_aready,
    // requester W channels
    input  logic [2*DW-1:0]       s_wdata,
    input  logic [2*(DW/8)-1:0]   s_wstrb,
    input  logic [1:0]            s_wlast,
    input  logic [1:0]            s_wvalid,
    output logic [1:0]            s_wready,
    // requester R channels
    output logic [15:0]           s_rid,
    output logic [2*DW-1:0]       s_rdata,
    output logic [3:0]            s_rresp,
    output logic [1:0]            s_rlast,
    output logic [1:0]            s_rvalid,
    input  logic [1:0]            s_rready,
    // requester B channels
    output logic [15:0]           s_bid,
    output logic [1:0]            s_bvalid,
    input  logic [1:0]            s_bready,
    // DDR A channel
    output logic [7:0]            m_aid,
    output logic [31:0]           m_aaddr,
    output logic [7:0]            m_alen,
    output logic [2:0]            m_asize,
    output logic [1:0]            m_aburst,
    output logic [1:0]            m_alock,
    output logic                  m_atype,
    output logic                  m_avalid,
    input  logic                  m_aready,
    // DDR W channel
    output logic [DW-1:0]         m_wdata,
    output logic [DW/8-1:0]       m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    // DDR R channel
    input  logic [7:0]            m_rid,
    input  logic [DW-1:0]         m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    // DDR B channel
    input  logic [7:0]            m_bid,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    // status
    output logic [1:0]            grant,
    output logic                  err_timeout,
    output logic                  err_wlast
);

    localparam int unsigned SW   = DW / 8;
    localparam int unsigned WDTW = $clog2(WDT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_BRESP,
        ST_RDATA
    } state_t;

    state_t            state_q;
    logic [1:0]        grant_q;
    logic              ptr_q;
    logic [7:0]        beat_q;
    logic [WDTW-1:0]   wdt_q;
    logic              err_timeout_q;
    logic              err_wlast_q;

    logic              gidx;
    logic              win_c;
    logic              a_hs;
    logic              w_hs;
    logic              b_hs;
    logic              r_last_hs;
    logic              leave_c;

    assign gidx  = grant_q[1];
    // ptr picks the winner on a tie, otherwise the sole requester wins
    assign win_c = (&s_avalid) ? ptr_q : s_avalid[1];

    assign grant       = grant_q;
    assign err_timeout = err_timeout_q;
    assign err_wlast   = err_wlast_q;

    // Route the granted lane to/from DDR; everything else held at zero
    always_comb begin
        s_aready  = '0;
        s_wready  = '0;
        s_rid     = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = '0;
        s_rvalid  = '0;
        s_bid     = '0;
        s_bvalid  = '0;
        m_aid     = '0;
        m_aaddr   = '0;
        m_alen    = '0;
        m_asize   = '0;
        m_aburst  = '0;
        m_alock   = '0;
        m_atype   = 1'b0;
        m_avalid  = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        m_wvalid  = 1'b0;
        m_rready  = 1'b0;
        m_bready  = 1'b0;
        a_hs      = 1'b0;
        w_hs      = 1'b0;
        b_hs      = 1'b0;
        r_last_hs = 1'b0;
        case (state_q)
            ST_ADDR: begin
                m_aid    = gidx ? s_aid[15:8]    : s_aid[7:0];
                m_aaddr  = gidx ? s_aaddr[63:32] : s_aaddr[31:0];
                m_alen   = gidx ? s_alen[15:8]   : s_alen[7:0];
                m_asize  = gidx ? s_asize[5:3]   : s_asize[2:0];
                m_aburst = gidx ? s_aburst[3:2]  : s_aburst[1:0];
                m_alock  = gidx ? s_alock[3:2]   : s_alock[1:0];
                m_atype  = s_atype[gidx];
                m_avalid = s_avalid[gidx];
                s_aready[gidx] = m_aready;
                a_hs     = m_avalid && m_aready;
            end
            ST_WDATA: begin
                m_wdata  = gidx ? s_wdata[2*DW-1:DW] : s_wdata[DW-1:0];
                m_wstrb  = gidx ? s_wstrb[2*SW-1:SW] : s_wstrb[SW-1:0];
                m_wlast  = s_wlast[gidx];
                m_wvalid = s_wvalid[gidx];
                s_wready[gidx] = m_wready;
                w_hs     = m_wvalid && m_wready;
            end
            ST_BRESP: begin
                if (gidx) s_bid[15:8] = m_bid;
                else      s_bid[7:0]  = m_bid;
                s_bvalid[gidx] = m_bvalid;
                m_bready = s_bready[gidx];
                b_hs     = m_bvalid && m_bready;
            end
            ST_RDATA: begin
                if (gidx) begin
                    s_rid[15:8]         = m_rid;
                    s_rdata[2*DW-1:DW]  = m_rdata;
                    s_rresp[3:2]        = m_rresp;
                end else begin
                    s_rid[7:0]          = m_rid;
                    s_rdata[DW-1:0]     = m_rdata;
                    s_rresp[1:0]        = m_rresp;
                end
                s_rlast[gidx]  = m_rlast;
                s_rvalid[gidx] = m_rvalid;
                m_rready  = s_rready[gidx];
                r_last_hs = m_rvalid && m_rready && m_rlast;
            end
            default: ;
        endcase
    end

    assign leave_c = a_hs || (w_hs && m_wlast) || b_hs || r_last_hs;

    // Arbitration FSM, beat counter, watchdog and sticky error flags
    always_ff @(posedge mem_clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            ptr_q         <= 1'b0;
            beat_q        <= '0;
            wdt_q         <= '0;
            err_timeout_q <= 1'b0;
            err_wlast_q   <= 1'b0;
        end else begin
            if (w_hs) begin
                if (m_wlast != (beat_q == 8'd0)) err_wlast_q <= 1'b1;
                if (beat_q != 8'd0) beat_q <= beat_q - 8'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    wdt_q <= '0;
                    if (|s_avalid) begin
                        state_q <= ST_ADDR;
                        grant_q <= win_c ? 2'b10 : 2'b01;
                        beat_q  <= win_c ? s_alen[15:8] : s_alen[7:0];
                    end
                end
                default: begin
                    if (leave_c) begin
                        wdt_q <= '0;
                        case (state_q)
                            ST_ADDR:  state_q <= m_atype ? ST_WDATA : ST_RDATA;
                            ST_WDATA: state_q <= ST_BRESP;
                            default: begin
                                state_q <= ST_IDLE;
                                grant_q <= '0;
                                ptr_q   <= ~gidx;
                            end
                        endcase
                    end else if (wdt_q == WDTW'(WDT_CYCLES - 1)) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_IDLE;
                        grant_q       <= '0;
                        ptr_q         <= ~gidx;
                        wdt_q         <= '0;
                    end else begin
                        wdt_q <= wdt_q + WDTW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_axi_2to1_arbiter.sv
// Directed bench for ddr_axi_2to1_arbiter: the bench plays both requesters
// and the DDR side, with hand-computed expectations checked by assertions.
module tb_ddr_axi_2to1_arbiter;

    localparam int unsigned DW = 128;

    logic             mem_clk;
    logic             resetn;
    logic [15:0]      s_aid;
    logic [63:0]      s_aaddr;
    logic [15:0]      s_alen;
    logic [5:0]       s_asize;
    logic [3:0]       s_aburst;
    logic [3:0]       s_alock;
    logic [1:0]       s_atype;
    logic [1:0]       s_avalid;
    logic [1:0]       s_aready;
    logic [2*DW-1:0]  s_wdata;
    logic [31:0]      s_wstrb;
    logic [1:0]       s_wlast;
    logic [1:0]       s_wvalid;
    logic [1:0]       s_wready;
    logic [15:0]      s_rid;
    logic [2*DW-1:0]  s_rdata;
    logic [3:0]       s_rresp;
    logic [1:0]       s_rlast;
    logic [1:0]       s_rvalid;
    logic [1:0]       s_rready;
    logic [15:0]      s_bid;
    logic [1:0]       s_bvalid;
    logic [1:0]       s_bready;
    logic [7:0]       m_aid;
    logic [31:0]      m_aaddr;
    logic [7:0]       m_alen;
    logic [2:0]       m_asize;
    logic [1:0]       m_aburst;
    logic [1:0]       m_alock;
    logic             m_atype;
    logic             m_avalid;
    logic             m_aready;
    logic [DW-1:0]    m_wdata;
    logic [15:0]      m_wstrb;
    logic             m_wlast;
    logic             m_wvalid;
    logic             m_wready;
    logic [7:0]       m_rid;
    logic [DW-1:0]    m_rdata;
    logic [1:0]       m_rresp;
    logic             m_rlast;
    logic             m_rvalid;
    logic             m_rready;
    logic [7:0]       m_bid;
    logic             m_bvalid;
    logic             m_bready;
    logic [1:0]       grant;
    logic             err_timeout;
    logic             err_wlast;

    int               n_assert;
    int               n_fail;
    logic             exp_wlast_err;
    logic [DW-1:0]    ddr_mem [0:3];

    ddr_axi_2to1_arbiter #(.DW(DW), .WDT_CYCLES(16)) dut (
        .mem_clk(mem_clk), .resetn(resetn),
        .s_aid(s_aid), .s_aaddr(s_aaddr), .s_alen(s_alen), .s_asize(s_asize),
        .s_aburst(s_aburst), .s_alock(s_alock), .s_atype(s_atype),
        .s_avalid(s_avalid), .s_aready(s_aready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_bid(s_bid), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_aid(m_aid), .m_aaddr(m_aaddr), .m_alen(m_alen), .m_asize(m_asize),
        .m_aburst(m_aburst), .m_alock(m_alock), .m_atype(m_atype),
        .m_avalid(m_avalid), .m_aready(m_aready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_bid(m_bid), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .grant(grant), .err_timeout(err_timeout), .err_wlast(err_wlast)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_aid = '0; s_aaddr = '0; s_alen = '0; s_asize = '0; s_aburst = '0;
        s_alock = '0; s_atype = '0; s_avalid = '0;
        s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0;
        s_rready = '0; s_bready = '0;
        m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        m_bid = '0; m_bvalid = 1'b0;
        m_aready = 1'b1; m_wready = 1'b1;
    endtask

    // Assert reset (outputs must clear with no clock edge), then release
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_m_avalid", m_avalid, 1'b0);
        chk("rst_m_wvalid", m_wvalid, 1'b0);
        chk("rst_m_wdata", m_wdata, '0);
        chk("rst_s_wready", s_wready, 2'b00);
        chk("rst_s_aready", s_aready, 2'b00);
        chk("rst_s_rvalid", s_rvalid, 2'b00);
        chk("rst_s_bvalid", s_bvalid, 2'b00);
        chk("rst_m_rready", m_rready, 1'b0);
        chk("rst_m_bready", m_bready, 1'b0);
        chk("rst_err_timeout", err_timeout, 1'b0);
        chk("rst_err_wlast", err_wlast, 1'b0);
        clear_inputs();
        tick();
        tick();
        resetn = 1'b1;
        exp_wlast_err = 1'b0;
    endtask

    task automatic req(input int p, input logic [7:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic atype);
        s_aid[p*8 +: 8]     = id;
        s_aaddr[p*32 +: 32] = addr;
        s_alen[p*8 +: 8]    = len;
        s_asize[p*3 +: 3]   = 3'd4;
        s_aburst[p*2 +: 2]  = 2'b01;
        s_alock[p*2 +: 2]   = 2'b00;
        s_atype[p]          = atype;
        s_avalid[p]         = 1'b1;
    endtask

    // Grant appears one edge after request; A handshake on the following edge
    task automatic addr_phase(input int p, input logic [7:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic atype);
        logic [1:0] g;
        g = (p == 0) ? 2'b01 : 2'b10;
        tick();
        chk("a_grant", grant, g);
        chk("a_m_avalid", m_avalid, 1'b1);
        chk("a_m_aid", m_aid, id);
        chk("a_m_aaddr", m_aaddr, addr);
        chk("a_m_alen", m_alen, len);
        chk("a_m_atype", m_atype, atype);
        chk("a_s_aready", s_aready, g);
        tick();
        s_avalid[p] = 1'b0;
    endtask

    task automatic do_read(input int p, input int n, input logic [127:0] d0,
                           input logic [127:0] d1, input bit from_mem);
        logic [1:0] g;
        g = (p == 0) ? 2'b01 : 2'b10;
        s_rready[p] = 1'b1;
        for (int i = 0; i < n; i++) begin
            m_rvalid = 1'b1;
            m_rid    = 8'h3C;
            m_rresp  = 2'b00;
            m_rlast  = (i == n - 1);
            m_rdata  = from_mem ? ddr_mem[i] : ((i % 2 == 0) ? d0 : d1);
            #1;
            chk("r_grant", grant, g);
            chk("r_s_rvalid", s_rvalid, g);
            chk("r_s_rdata", s_rdata[p*128 +: 128], (i % 2 == 0) ? d0 : d1);
            chk("r_other_rdata", s_rdata[(1-p)*128 +: 128], '0);
            chk("r_s_rid", s_rid[p*8 +: 8], 8'h3C);
            chk("r_s_rlast", s_rlast, (i == n - 1) ? g : 2'b00);
            chk("r_m_rready", m_rready, 1'b1);
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready[p] = 1'b0;
        #1;
        chk("r_exit_grant", grant, 2'b00);
        chk("r_exit_rvalid", s_rvalid, 2'b00);
    endtask

    task automatic do_write(input int p, input int len, input int last_at,
                            input logic [127:0] d0, input logic [127:0] d1,
                            input logic [7:0] id);
        logic [1:0] g;
        logic       last;
        g = (p == 0) ? 2'b01 : 2'b10;
        s_wvalid[p] = 1'b1;
        for (int i = 0; i <= last_at; i++) begin
            last = (i == last_at);
            s_wdata[p*128 +: 128] = (i % 2 == 0) ? d0 : d1;
            s_wstrb[p*16 +: 16]   = 16'hFFFF;
            s_wlast[p]            = last;
            #1;
            chk("w_m_wvalid", m_wvalid, 1'b1);
            chk("w_m_wdata", m_wdata, (i % 2 == 0) ? d0 : d1);
            chk("w_m_wstrb", m_wstrb, 16'hFFFF);
            chk("w_m_wlast", m_wlast, last);
            chk("w_s_wready", s_wready, g);
            if (i < 4) ddr_mem[i] = m_wdata;
            if (last != ((len - i) == 0)) exp_wlast_err = 1'b1;
            tick();
            chk("w_err_wlast", err_wlast, exp_wlast_err);
        end
        s_wvalid[p] = 1'b0;
        s_wlast[p]  = 1'b0;
        m_bvalid = 1'b1;
        m_bid    = id;
        s_bready[p] = 1'b1;
        #1;
        chk("b_grant", grant, g);
        chk("b_s_bvalid", s_bvalid, g);
        chk("b_s_bid", s_bid[p*8 +: 8], id);
        chk("b_m_bready", m_bready, 1'b1);
        tick();
        m_bvalid = 1'b0;
        s_bready[p] = 1'b0;
        #1;
        chk("b_exit_grant", grant, 2'b00);
        chk("b_exit_bvalid", s_bvalid, 2'b00);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_wlast_err = 1'b0;
        resetn = 1'b0;
        clear_inputs();
        do_reset();

        // Port0 read, 4 beats; m_avalid only after the registered grant
        req(0, 8'h11, 32'h0000_1000, 8'd3, 1'b0);
        #1;
        chk("pre_grant", grant, 2'b00);
        chk("pre_m_avalid", m_avalid, 1'b0);
        addr_phase(0, 8'h11, 32'h0000_1000, 8'd3, 1'b0);
        do_read(0, 4, {4{32'h1111_1111}}, {4{32'h2222_2222}}, 1'b0);

        // Port1 write of two beats, then read back what DDR captured
        req(1, 8'h22, 32'h0000_2000, 8'd1, 1'b1);
        addr_phase(1, 8'h22, 32'h0000_2000, 8'd1, 1'b1);
        do_write(1, 1, 1, {16{8'hA5}}, {16{8'h5A}}, 8'h22);
        chk("t2_err_wlast", err_wlast, 1'b0);
        req(1, 8'h23, 32'h0000_2000, 8'd1, 1'b0);
        addr_phase(1, 8'h23, 32'h0000_2000, 8'd1, 1'b0);
        do_read(1, 2, {16{8'hA5}}, {16{8'h5A}}, 1'b1);

        // Contest after reset: port0, then port1, then port0 again
        do_reset();
        req(0, 8'h31, 32'h0000_3000, 8'd0, 1'b1);
        req(1, 8'h32, 32'h0000_3100, 8'd0, 1'b0);
        addr_phase(0, 8'h31, 32'h0000_3000, 8'd0, 1'b1);
        do_write(0, 0, 0, {4{32'hC0DE_0001}}, {4{32'hC0DE_0001}}, 8'h31);
        addr_phase(1, 8'h32, 32'h0000_3100, 8'd0, 1'b0);
        do_read(1, 1, {4{32'hBEEF_0002}}, {4{32'hBEEF_0002}}, 1'b0);
        req(0, 8'h33, 32'h0000_3200, 8'd0, 1'b0);
        req(1, 8'h34, 32'h0000_3300, 8'd0, 1'b0);
        addr_phase(0, 8'h33, 32'h0000_3200, 8'd0, 1'b0);
        do_read(0, 1, {4{32'h0000_0033}}, {4{32'h0000_0033}}, 1'b0);
        addr_phase(1, 8'h34, 32'h0000_3300, 8'd0, 1'b0);
        do_read(1, 1, {4{32'h0000_0034}}, {4{32'h0000_0034}}, 1'b0);

        // alen=2 write ending early with wlast on beat 2 -> sticky err_wlast
        req(0, 8'h41, 32'h0000_4000, 8'd2, 1'b1);
        addr_phase(0, 8'h41, 32'h0000_4000, 8'd2, 1'b1);
        do_write(0, 2, 1, {4{32'h4444_0000}}, {4{32'h4444_1111}}, 8'h41);
        chk("t4_err_wlast_set", err_wlast, 1'b1);
        req(1, 8'h42, 32'h0000_4100, 8'd0, 1'b0);
        addr_phase(1, 8'h42, 32'h0000_4100, 8'd0, 1'b0);
        do_read(1, 1, {4{32'h4242_4242}}, {4{32'h4242_4242}}, 1'b0);
        chk("t4_err_wlast_hold", err_wlast, 1'b1);

        // Watchdog: port0 read stalled by rready=0 for 16 RDATA cycles
        req(0, 8'h51, 32'h0000_5000, 8'd3, 1'b0);
        addr_phase(0, 8'h51, 32'h0000_5000, 8'd3, 1'b0);
        m_rvalid = 1'b1;
        m_rdata  = {4{32'h5151_5151}};
        for (int i = 0; i < 16; i++) begin
            chk("wdt_err_low", err_timeout, 1'b0);
            chk("wdt_grant", grant, 2'b01);
            chk("wdt_m_rready", m_rready, 1'b0);
            tick();
        end
        chk("wdt_err_set", err_timeout, 1'b1);
        chk("wdt_grant_drop", grant, 2'b00);
        chk("wdt_s_rvalid", s_rvalid, 2'b00);
        m_rvalid = 1'b0;
        // Timed-out port0 loses the next contest
        req(0, 8'h52, 32'h0000_5100, 8'd0, 1'b0);
        req(1, 8'h53, 32'h0000_5200, 8'd0, 1'b0);
        addr_phase(1, 8'h53, 32'h0000_5200, 8'd0, 1'b0);
        do_read(1, 1, {4{32'h5353_5353}}, {4{32'h5353_5353}}, 1'b0);
        addr_phase(0, 8'h52, 32'h0000_5100, 8'd0, 1'b0);
        do_read(0, 1, {4{32'h5252_5252}}, {4{32'h5252_5252}}, 1'b0);
        chk("wdt_err_hold", err_timeout, 1'b1);

        // Reset during the first write beat, then a clean transaction
        req(0, 8'h61, 32'h0000_6000, 8'd3, 1'b1);
        addr_phase(0, 8'h61, 32'h0000_6000, 8'd3, 1'b1);
        s_wvalid[0] = 1'b1;
        s_wdata[127:0] = {4{32'h6161_6161}};
        s_wstrb[15:0]  = 16'hFFFF;
        #1;
        chk("t6_m_wvalid", m_wvalid, 1'b1);
        do_reset();
        req(1, 8'h62, 32'h0000_6100, 8'd1, 1'b0);
        addr_phase(1, 8'h62, 32'h0000_6100, 8'd1, 1'b0);
        do_read(1, 2, {4{32'h6262_0000}}, {4{32'h6262_1111}}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
